// File: rtl/rv32_mem_pkg.sv
// Shared RV32 memory-side definitions: funct3 codes, dcache FSM encoding, block geometry.
package rv32_mem_pkg;

  localparam int unsigned BLOCK_W  = 128;
  localparam int unsigned OFFSET_W = 4;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic [1:0] {
    StIdle      = 2'd0,
    StWriteback = 2'd1,
    StAllocate  = 2'd2,
    StUpdate    = 2'd3
  } dcache_state_e;

endpackage

// File: rtl/dcache_lsu_align.sv
// RV32 load extraction/extension and store merge on a single 32-bit word.
module dcache_lsu_align
  import rv32_mem_pkg::*;
(
  input  logic [2:0]  i_funct3,
  input  logic [1:0]  i_offset,
  input  logic [31:0] i_word,
  input  logic [31:0] i_wdata,
  output logic [31:0] o_load_data,
  output logic [31:0] o_store_word
);

  logic [7:0]  w_byte;
  logic [15:0] w_half;

  assign w_byte = i_word[{i_offset, 3'b000} +: 8];
  assign w_half = i_offset[1] ? i_word[31:16] : i_word[15:0];

  always_comb begin
    o_load_data = i_word;
    case (i_funct3)
      F3_B:    o_load_data = {{24{w_byte[7]}}, w_byte};
      F3_BU:   o_load_data = {24'd0, w_byte};
      F3_H:    o_load_data = {{16{w_half[15]}}, w_half};
      F3_HU:   o_load_data = {16'd0, w_half};
      default: o_load_data = i_word;
    endcase
  end

  // Address bit 0 is ignored for halves, bits [1:0] for words: no misalignment trap.
  always_comb begin
    o_store_word = i_word;
    case (i_funct3)
      F3_B:    o_store_word[{i_offset, 3'b000} +: 8] = i_wdata[7:0];
      F3_H:    o_store_word[{i_offset[1], 4'b0000} +: 16] = i_wdata[15:0];
      default: o_store_word = i_wdata;
    endcase
  end

endmodule

// File: rtl/dcache_ctrl.sv
// Direct-mapped write-back/write-allocate data cache controller for the MEM stage.
module dcache_ctrl
  import rv32_mem_pkg::*;
#(
  parameter int unsigned NUM_SETS = 8,
  parameter int unsigned ADDR_W   = 32
) (
  input  logic                       CLK,
  input  logic                       RESET,
  input  logic                       MEM_READ_EN,
  input  logic                       MEM_WRITE_EN,
  input  logic [2:0]                 FUNCT3,
  input  logic [ADDR_W-1:0]          ADDRESS,
  input  logic [31:0]                WRITE_DATA,
  output logic [31:0]                READ_DATA,
  output logic                       MEM_BUSYWAIT,
  output logic                       MAIN_MEM_READ,
  output logic                       MAIN_MEM_WRITE,
  output logic [ADDR_W-OFFSET_W-1:0] MAIN_MEM_ADDRESS,
  output logic [BLOCK_W-1:0]         MAIN_MEM_WRITE_DATA,
  input  logic [BLOCK_W-1:0]         MAIN_MEM_READ_DATA,
  input  logic                       MAIN_MEM_BUSYWAIT
);

  localparam int unsigned IDX_W = $clog2(NUM_SETS);
  localparam int unsigned TAG_W = ADDR_W - OFFSET_W - IDX_W;

  dcache_state_e r_state, w_state_next;

  logic [NUM_SETS-1:0] r_valid, r_dirty;
  logic [TAG_W-1:0]    r_tag  [NUM_SETS];
  logic [BLOCK_W-1:0]  r_data [NUM_SETS];
  logic [BLOCK_W-1:0]  r_fill;

  logic [IDX_W-1:0]   w_index;
  logic [TAG_W-1:0]   w_tag;
  logic [1:0]         w_word_sel;
  logic [BLOCK_W-1:0] w_line, w_merged_line;
  logic [31:0]        w_cur_word, w_load_data, w_store_word;
  logic               w_req, w_hit;
  logic               w_hit_we, w_fill_cap, w_fill_we;

  assign w_index    = ADDRESS[OFFSET_W +: IDX_W];
  assign w_tag      = ADDRESS[ADDR_W-1 -: TAG_W];
  assign w_word_sel = ADDRESS[3:2];
  assign w_line     = r_data[w_index];
  assign w_cur_word = w_line[{w_word_sel, 5'b00000} +: 32];
  assign w_req      = MEM_READ_EN | MEM_WRITE_EN;
  assign w_hit      = r_valid[w_index] && (r_tag[w_index] == w_tag) && w_req;

  dcache_lsu_align u_align (
    .i_funct3     (FUNCT3),
    .i_offset     (ADDRESS[1:0]),
    .i_word       (w_cur_word),
    .i_wdata      (WRITE_DATA),
    .o_load_data  (w_load_data),
    .o_store_word (w_store_word)
  );

  always_comb begin
    w_merged_line = w_line;
    w_merged_line[{w_word_sel, 5'b00000} +: 32] = w_store_word;
  end

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) r_state <= StIdle;
    else        r_state <= w_state_next;
  end

  always_comb begin
    w_state_next        = r_state;
    MEM_BUSYWAIT        = 1'b1;
    READ_DATA           = '0;
    MAIN_MEM_READ       = 1'b0;
    MAIN_MEM_WRITE      = 1'b0;
    MAIN_MEM_ADDRESS    = '0;
    MAIN_MEM_WRITE_DATA = '0;
    w_hit_we            = 1'b0;
    w_fill_cap          = 1'b0;
    w_fill_we           = 1'b0;
    unique case (r_state)
      StIdle: begin
        MEM_BUSYWAIT = 1'b0;
        if (w_req) begin
          if (w_hit) begin
            // Simultaneous read and write enables resolve to a write.
            if (MEM_WRITE_EN) w_hit_we  = 1'b1;
            else              READ_DATA = w_load_data;
          end else begin
            MEM_BUSYWAIT = 1'b1;
            w_state_next = (r_valid[w_index] && r_dirty[w_index]) ? StWriteback : StAllocate;
          end
        end
      end
      StWriteback: begin
        MAIN_MEM_WRITE      = 1'b1;
        MAIN_MEM_ADDRESS    = {r_tag[w_index], w_index};
        MAIN_MEM_WRITE_DATA = w_line;
        if (!MAIN_MEM_BUSYWAIT) w_state_next = StAllocate;
      end
      StAllocate: begin
        MAIN_MEM_READ    = 1'b1;
        MAIN_MEM_ADDRESS = {w_tag, w_index};
        if (!MAIN_MEM_BUSYWAIT) begin
          w_fill_cap   = 1'b1;
          w_state_next = StUpdate;
        end
      end
      StUpdate: begin
        w_fill_we    = 1'b1;
        w_state_next = StIdle;
      end
      default: w_state_next = StIdle;
    endcase
  end

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      r_valid <= '0;
      r_dirty <= '0;
    end else if (w_fill_we) begin
      r_valid[w_index] <= 1'b1;
      r_dirty[w_index] <= 1'b0;
    end else if (w_hit_we) begin
      r_dirty[w_index] <= 1'b1;
    end
  end

  // Data, tag and fill storage carry no reset; valid bits guard their contents.
  always_ff @(posedge CLK) begin
    if (w_fill_cap) r_fill <= MAIN_MEM_READ_DATA;
    if (w_fill_we) begin
      r_data[w_index] <= r_fill;
      r_tag[w_index]  <= w_tag;
    end else if (w_hit_we) begin
      r_data[w_index] <= w_merged_line;
    end
  end

endmodule
